// File: rtl/ofdm_demap_pkg.sv
// Shared types and helpers for the OFDM QAM bit demapper: legal modulation orders,
// the order type and the packer state encoding.
package ofdm_demap_pkg;

  localparam int MAX_ORDER_LIMIT = 8;
  localparam int ORDER_W         = $clog2(MAX_ORDER_LIMIT) + 1;

  typedef logic [ORDER_W-1:0] order_t;

  localparam order_t ORDER_BPSK   = order_t'(1);
  localparam order_t ORDER_QPSK   = order_t'(2);
  localparam order_t ORDER_QAM16  = order_t'(4);
  localparam order_t ORDER_QAM64  = order_t'(6);
  localparam order_t ORDER_QAM256 = order_t'(8);

  typedef enum logic {
    RUN,
    FLUSH
  } pack_state_t;

  function automatic logic is_legal_order(input logic [31:0] value, input int max_order);
    logic known;
    known = (value == 32'd1) || (value == 32'd2) || (value == 32'd4) ||
            (value == 32'd6) || (value == 32'd8);
    return known && (value <= 32'(max_order));
  endfunction

endpackage

// File: rtl/qam_gray_slicer.sv
// One-axis hard-decision slicer: rounds a fixed-point sample to the nearest odd
// constellation level and registers its Gray code behind a valid/ready handshake.
module qam_gray_slicer #(
  parameter int WIDTH_IN  = 16,
  parameter int FRAC_BITS = 8,
  parameter int MAX_K     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [$clog2(MAX_K):0]     k,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH_IN-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MAX_K-1:0]           gray
);

  localparam int SW = WIDTH_IN + 2;

  logic signed [SW-1:0] x_ext, m, one_k, lvl_max, idx_s;
  logic [MAX_K-1:0]     idx;

  // Levels sit on odd integers, so boundaries land on even integers; the floor
  // shift followed by +2^k and a halving sends a tie to the higher level.
  always_comb begin
    x_ext   = {{2{in_data[WIDTH_IN-1]}}, in_data};
    m       = x_ext >>> FRAC_BITS;
    one_k   = SW'(1) << k;
    lvl_max = one_k - SW'(1);
    idx_s   = (m + one_k) >>> 1;
    if (idx_s[SW-1])            idx = '0;
    else if (idx_s > lvl_max)   idx = lvl_max[MAX_K-1:0];
    else                        idx = idx_s[MAX_K-1:0];
  end

  assign in_ready = !out_valid || out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_valid <= 1'b0;
      gray      <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) gray <= idx ^ (idx >> 1);
    end
  end

endmodule

// File: rtl/ofdm_qam_bit_demapper.sv
// Hard-decision QAM demapper and bit packer (BPSK..QAM-256), per-packet order latch,
// zero-padded flush on tlast. Define OFDM_DEMAP_BIT_REVERSE_EN for LSB-first bytes.
module ofdm_qam_bit_demapper
  import ofdm_demap_pkg::*;
#(
  parameter int WIDTH_IN            = 16,
  parameter int FRAC_BITS           = 8,
  parameter int MAX_ORDER           = 8,
  parameter int OUT_WIDTH           = 32,
  parameter int SR_MODULATION_ORDER = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic [2*WIDTH_IN-1:0]   i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [OUT_WIDTH-1:0]    o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
);

  localparam int MAX_K = MAX_ORDER / 2;
  localparam int KW    = $clog2(MAX_K) + 1;
  localparam int AW    = OUT_WIDTH + MAX_ORDER - 1;
  localparam int CW    = $clog2(AW + 1);

  logic        flush;
  order_t      order_reg, active_order, beat_order, s1_order;
  logic        first_beat, s1_last, accept;
  logic [KW-1:0] beat_k;
  logic        slice_in_valid, rdy_i, rdy_q, v_i, v_q, s1_valid;
  logic [MAX_K-1:0] gray_i, gray_q;

  pack_state_t state, state_nxt;
  logic [AW-1:0] acc, acc_nxt, sym_al, merged;
  logic [CW-1:0] cnt, cnt_nxt, total, rem;
  logic [MAX_ORDER-1:0] sym;
  logic out_free, consume, completes, load;
  logic [OUT_WIDTH-1:0] word;
  logic word_last;

  assign flush = reset || clear;

  always_ff @(posedge clk) begin
    if (reset)
      order_reg <= ORDER_QPSK;
    else if (set_stb && set_addr == 8'(SR_MODULATION_ORDER) &&
             is_legal_order(set_data, MAX_ORDER))
      order_reg <= order_t'(set_data);
  end

  // The first beat of a packet uses the register directly; later beats use the latch.
  assign beat_order = first_beat ? order_reg : active_order;
  assign beat_k     = (beat_order == ORDER_BPSK) ? KW'(1) : KW'(beat_order >> 1);

  assign slice_in_valid = i_tvalid && state == RUN && !flush;
  assign i_tready       = rdy_i && rdy_q && state == RUN && !flush;
  assign accept         = i_tvalid && i_tready;
  assign s1_valid       = v_i && v_q;

  qam_gray_slicer #(.WIDTH_IN(WIDTH_IN), .FRAC_BITS(FRAC_BITS), .MAX_K(MAX_K)) slicer_i (
    .clk(clk), .reset(reset), .clear(clear), .k(beat_k),
    .in_valid(slice_in_valid), .in_ready(rdy_i), .in_data(i_tdata[2*WIDTH_IN-1:WIDTH_IN]),
    .out_valid(v_i), .out_ready(consume), .gray(gray_i)
  );

  qam_gray_slicer #(.WIDTH_IN(WIDTH_IN), .FRAC_BITS(FRAC_BITS), .MAX_K(MAX_K)) slicer_q (
    .clk(clk), .reset(reset), .clear(clear), .k(beat_k),
    .in_valid(slice_in_valid), .in_ready(rdy_q), .in_data(i_tdata[WIDTH_IN-1:0]),
    .out_valid(v_q), .out_ready(consume), .gray(gray_q)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      first_beat   <= 1'b1;
      active_order <= ORDER_QPSK;
      s1_order     <= ORDER_QPSK;
      s1_last      <= 1'b0;
    end else if (accept) begin
      if (first_beat) active_order <= order_reg;
      first_beat <= i_tlast;
      s1_order   <= beat_order;
      s1_last    <= i_tlast;
    end
  end

  assign out_free = !o_tvalid || o_tready;
  assign consume  = s1_valid && state == RUN && out_free;

  // Accumulator holds cnt valid bits left-aligned; everything below them is zero.
  always_comb begin
    if (s1_order == ORDER_BPSK) sym = MAX_ORDER'(gray_i[0]);
    else sym = (MAX_ORDER'(gray_i) << (s1_order >> 1)) | MAX_ORDER'(gray_q);
    sym_al    = (AW'(sym) << (AW - int'(s1_order))) >> cnt;
    merged    = acc | sym_al;
    total     = cnt + CW'(s1_order);
    completes = total >= CW'(OUT_WIDTH);
    rem       = total - CW'(OUT_WIDTH);
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    state_nxt = state;
    load      = 1'b0;
    word      = '0;
    word_last = 1'b0;
    if (state == FLUSH) begin
      if (out_free) begin
        load      = 1'b1;
        word      = acc[AW-1 -: OUT_WIDTH];
        word_last = 1'b1;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = RUN;
      end
    end else if (consume) begin
      if (completes) begin
        load    = 1'b1;
        word    = merged[AW-1 -: OUT_WIDTH];
        acc_nxt = merged << OUT_WIDTH;
        cnt_nxt = rem;
        if (s1_last) begin
          if (rem == '0) word_last = 1'b1;
          else           state_nxt = FLUSH;
        end
      end else if (s1_last) begin
        load      = 1'b1;
        word      = merged[AW-1 -: OUT_WIDTH];
        word_last = 1'b1;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end else begin
        acc_nxt = merged;
        cnt_nxt = total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc   <= '0;
      cnt   <= '0;
      state <= RUN;
    end else begin
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  function automatic logic [OUT_WIDTH-1:0] byte_order(input logic [OUT_WIDTH-1:0] w);
`ifdef OFDM_DEMAP_BIT_REVERSE_EN
    for (int b = 0; b < OUT_WIDTH / 8; b++)
      for (int j = 0; j < 8; j++)
        byte_order[8*b+j] = w[8*b+7-j];
`else
    byte_order = w;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (flush) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (load) begin
      o_tvalid <= 1'b1;
      o_tdata  <= byte_order(word);
      o_tlast  <= word_last;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofdm_qam_bit_demapper.sv
// Self-checking bench: a bit-queue model of the demapper checked every output
// transfer, plus literal word expectations for the directed packets.
module tb_ofdm_qam_bit_demapper;

  localparam int WIDTH_IN  = 16;
  localparam int FRAC_BITS = 8;
  localparam int MAX_ORDER = 8;
  localparam int OUT_WIDTH = 32;

  logic clk, reset, clear, set_stb;
  logic [7:0] set_addr;
  logic [31:0] set_data;
  logic [2*WIDTH_IN-1:0] i_tdata;
  logic i_tlast, i_tvalid, i_tready;
  logic [OUT_WIDTH-1:0] o_tdata;
  logic o_tlast, o_tvalid, o_tready;

  ofdm_qam_bit_demapper #(
    .WIDTH_IN(WIDTH_IN), .FRAC_BITS(FRAC_BITS), .MAX_ORDER(MAX_ORDER),
    .OUT_WIDTH(OUT_WIDTH), .SR_MODULATION_ORDER(0)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  int    bitq[$];
  int    m_reg = 2;
  int    m_active = 2;
  bit    m_first = 1'b1;

  function automatic logic [OUT_WIDTH-1:0] rev(input logic [OUT_WIDTH-1:0] w);
`ifdef OFDM_DEMAP_BIT_REVERSE_EN
    logic [OUT_WIDTH-1:0] r;
    for (int b = 0; b < OUT_WIDTH / 8; b++)
      for (int j = 0; j < 8; j++)
        r[8*b+j] = w[8*b+7-j];
    return r;
`else
    return w;
`endif
  endfunction

  // Nearest odd level on a 2^k-level axis, then Gray-coded.
  function automatic int gray_axis(input int x, input int k);
    int lvl;
    lvl = ((x >>> FRAC_BITS) + (1 << k)) >>> 1;
    if (lvl < 0) lvl = 0;
    if (lvl > (1 << k) - 1) lvl = (1 << k) - 1;
    return lvl ^ (lvl >> 1);
  endfunction

  function automatic void push_word(input bit last);
    word_t w;
    w.data = '0;
    for (int b = OUT_WIDTH - 1; b >= 0; b--)
      if (bitq.size() > 0) w.data[b] = 1'(bitq.pop_front());
    w.data = rev(w.data);
    w.last = last;
    exp_q.push_back(w);
  endfunction

  function automatic void model_beat(input int i_val, input int q_val, input bit last);
    int ord, k, gi, gq;
    if (m_first) m_active = m_reg;
    m_first = last;
    ord = m_active;
    if (ord == 1) begin
      bitq.push_back(gray_axis(i_val, 1) & 1);
    end else begin
      k  = ord / 2;
      gi = gray_axis(i_val, k);
      gq = gray_axis(q_val, k);
      for (int b = k - 1; b >= 0; b--) bitq.push_back((gi >> b) & 1);
      for (int b = k - 1; b >= 0; b--) bitq.push_back((gq >> b) & 1);
    end
    while (bitq.size() >= OUT_WIDTH) push_word(last && bitq.size() == OUT_WIDTH);
    if (last && bitq.size() > 0) push_word(1'b1);
  endfunction

  function automatic void model_clear(input bit full_reset);
    bitq.delete();
    exp_q.delete();
    m_first  = 1'b1;
    m_active = 2;
    if (full_reset) m_reg = 2;
  endfunction

  task automatic write_order(input int v);
    set_stb = 1'b1; set_addr = 8'd0; set_data = 32'(v);
    @(posedge clk); #1;
    set_stb = 1'b0;
    if ((v == 1 || v == 2 || v == 4 || v == 6 || v == 8) && v <= MAX_ORDER) m_reg = v;
  endtask

  task automatic send_beat(input int i_val, input int q_val, input bit last);
    bit done;
    done = 1'b0;
    i_tdata  = {16'(i_val), 16'(q_val)};
    i_tlast  = last;
    i_tvalid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (i_tready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    check("beat accepted", 64'(done), 1);
    if (done) model_beat(i_val, q_val, last);
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("all expected words delivered", 64'(exp_q.size()), 0);
  endtask

  task automatic pin(input string name, input int idx, input logic [31:0] d, input logic l);
    check({name, " present"}, 64'(got_q.size() > idx), 1);
    if (got_q.size() > idx) begin
      check({name, " data"}, 64'(got_q[idx].data), 64'(rev(d)));
      check({name, " last"}, 64'(got_q[idx].last), 64'(l));
    end
  endtask

  // Compare process: every output transfer against the model, plus hold stability.
  bit prev_stall = 1'b0;
  logic [OUT_WIDTH-1:0] prev_data;
  logic prev_last;
  bit count_en = 1'b0;
  int low_cnt = 0;

  always @(negedge clk) begin
    if (reset || clear) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("held valid", 64'(o_tvalid), 1);
        check("held data", 64'(o_tdata), 64'(prev_data));
        check("held last", 64'(o_tlast), 64'(prev_last));
      end
      if (o_tvalid && o_tready) begin
        word_t g;
        g.data = o_tdata;
        g.last = o_tlast;
        got_q.push_back(g);
        check("word expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          word_t e;
          e = exp_q.pop_front();
          check("word data", 64'(o_tdata), 64'(e.data));
          check("word last", 64'(o_tlast), 64'(e.last));
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      if (count_en && !i_tready) low_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_clear(1'b1);
    @(negedge clk);
    check("reset o_tvalid", 64'(o_tvalid), 0);
    check("reset o_tlast", 64'(o_tlast), 0);
    check("reset o_tdata", 64'(o_tdata), 0);
    check("reset i_tready", 64'(i_tready), 1);

    // BPSK alternating +1/-1
    got_q.delete();
    write_order(1);
    for (int n = 0; n < 32; n++) send_beat((n % 2 == 0) ? 'h100 : -'h100, 'h7fff, n == 31);
    drain();
    pin("bpsk", 0, 32'hAAAA_AAAA, 1'b1);

    // QAM-16, then the same with I on the +2 boundary
    got_q.delete();
    write_order(4);
    for (int n = 0; n < 8; n++) send_beat('h300, -'h100, n == 7);
    for (int n = 0; n < 8; n++) send_beat('h200, -'h100, n == 7);
    drain();
    pin("qam16", 0, 32'h9999_9999, 1'b1);
    pin("qam16 tie", 1, 32'h9999_9999, 1'b1);

    // QAM-64 36 bits: full word plus flushed residue, one stall cycle
    got_q.delete();
    write_order(6);
    low_cnt = 0;
    count_en = 1'b1;
    for (int n = 0; n < 6; n++) send_beat('h200, 'h200, n == 5);
    repeat (8) @(posedge clk);
    #1 count_en = 1'b0;
    check("flush stall cycles", 64'(low_cnt), 1);
    drain();
    pin("qam64 w0", 0, 32'hFFFF_FFFF, 1'b0);
    pin("qam64 w1", 1, 32'hF000_0000, 1'b1);

    // Mid-packet order change, then an illegal write
    got_q.delete();
    write_order(4);
    for (int n = 0; n < 4; n++) send_beat('h300, -'h100, 1'b0);
    write_order(8);
    for (int n = 0; n < 4; n++) send_beat('h300, -'h100, n == 3);
    for (int n = 0; n < 4; n++) send_beat('h400, 'h400, n == 3);
    write_order(5);
    for (int n = 0; n < 4; n++) send_beat('h400, -'h800, n == 3);
    drain();
    pin("order held", 0, 32'h9999_9999, 1'b1);
    pin("order next", 1, 32'hFFFF_FFFF, 1'b1);
    pin("order illegal", 2, 32'hF6F6_F6F6, 1'b1);

    // Output backpressure for 10 cycles mid-stream
    got_q.delete();
    write_order(2);
    fork
      for (int n = 0; n < 48; n++)
        send_beat((n % 2 == 0) ? 'h100 : -'h100, (n % 3 == 0) ? 'h100 : -'h100, n == 47);
      begin
        repeat (20) @(posedge clk);
        #1 o_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1 o_tready = 1'b1;
      end
    join
    drain();
    check("stall word count", 64'(got_q.size()), 3);

    // Reset mid-packet discards in-flight bits and restores QPSK
    got_q.delete();
    write_order(4);
    for (int n = 0; n < 3; n++) send_beat('h300, 'h300, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset o_tvalid", 64'(o_tvalid), 0);
    reset = 1'b0;
    model_clear(1'b1);
    for (int n = 0; n < 16; n++) send_beat('h100, -'h100, n == 15);
    drain();
    pin("after reset", 0, 32'hAAAA_AAAA, 1'b1);

    // Clear keeps the order and wins over a simultaneous beat
    got_q.delete();
    write_order(8);
    for (int n = 0; n < 2; n++) send_beat('h400, 'h400, 1'b0);
    i_tdata = {16'h0400, 16'h0400}; i_tvalid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; i_tvalid = 1'b0;
    model_clear(1'b0);
    for (int n = 0; n < 4; n++) send_beat('h400, -'h800, n == 3);
    drain();
    pin("after clear", 0, 32'hF6F6_F6F6, 1'b1);

    // BPSK single-one-per-byte pattern
    got_q.delete();
    write_order(1);
    for (int n = 0; n < 32; n++) send_beat((n % 8 == 0) ? 'h100 : -'h100, 0, n == 31);
    drain();
    pin("byte order", 0, 32'h8080_8080, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofdm_qam_bit_demapper.md
# ofdm_qam_bit_demapper

Generalised hard-decision QAM demapper and bit packer for the OFDM receive chain, placed after subcarrier puncturing, equalisation scaling and rounding to signed I/Q. Supports BPSK through QAM-256 and any byte-multiple output width. Modulation order is latched per packet. A partial final word is flushed, zero-padded, on input tlast. It replaces fixed 32-bit, QAM-64-max packing, which had no packet-boundary handling.

## Interface
- WIDTH_IN, 16: signed width of each I and Q component.
- FRAC_BITS, 8: fractional bits; constellation point ±1 = ±2^FRAC_BITS.
- MAX_ORDER, 8: maximum bits/symbol; legal orders are 1, 2, 4, 6, 8 up to MAX_ORDER.
- OUT_WIDTH, 32: output word width; multiple of 8, ≥ MAX_ORDER.
- SR_MODULATION_ORDER, 0: settings address of the modulation order.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush; same effect as reset except the settings register is kept.
- set_stb, set_addr[7:0], set_data[31:0]  in  settings bus.
- i_tdata  in  2*WIDTH_IN  {I, Q}, I in the upper half.
- i_tlast, i_tvalid  in  1 each.
- i_tready  out  1.
- o_tdata  out  OUT_WIDTH  packed bits; first received bit at the MSB.
- o_tlast, o_tvalid  out  1 each.
- o_tready  in  1.

## Operation
- Settings register: a write of a legal order is stored; an illegal order (0, 3, 5, 7, or > MAX_ORDER) is ignored. Reset value 2 (QPSK).
- Active order: the register value is copied into the active order on the first accepted beat of each packet. A packet's first beat is the first beat after reset, clear, or a beat with tlast. A settings write mid-packet takes effect at the next packet.
- Per-axis bits k = order/2. BPSK uses k=1 on I only, and Q is ignored.
- Slicing, per axis:
  - m = x >>> FRAC_BITS (arithmetic shift, floor).
  - idx = clamp((m + 2^k) >>> 1, 0, 2^k − 1).
  - gray = idx ^ (idx >> 1), MSB first.
  - Decision boundaries fall on even integers; a tie resolves to the higher level.
- Symbol bits: {gray_I, gray_Q}, I first. BPSK yields gray_I only.
- Packer:
  - Accumulator is OUT_WIDTH+MAX_ORDER−1 bits, plus a bit count cnt.
  - Each symbol's bits are appended below the existing bits.
  - When cnt+order ≥ OUT_WIDTH, the top OUT_WIDTH bits are emitted and the remainder is kept left-aligned.
- tlast handling:
  - If bits remain after appending the last symbol, one extra word is emitted: remaining bits MSB-aligned, zero-padded, o_tlast=1.
  - If the last symbol exactly completes a word, that word carries o_tlast=1 and no extra word is emitted.
  - An empty residue never produces an empty word.
- Packer state machine:
  - RUN: normal packing.
  - FLUSH: entered when one input beat both completes a word and leaves residue with tlast. It emits the residue word next, holds i_tready=0, and returns to RUN with cnt=0.

## Timing
- Stage 1 is the slicer register; stage 2 is the output register. The output register holds o_tdata, o_tvalid and o_tlast.
- Latency: the input beat that completes a word → o_tvalid 2 cycles later when o_tready=1.
- Throughput: one symbol per cycle, except one stall cycle per FLUSH.
- Backpressure: every stage advances when its downstream register is empty or being read. i_tready = stage-1 register can advance AND state ≠ FLUSH.
- Output stability: o_tdata and o_tlast are held stable while o_tvalid=1 and o_tready=0.
- Reset/clear values: o_tvalid=0, o_tlast=0, o_tdata=0, cnt=0, state=RUN, active order=2. In-flight bits are discarded.
- Clear asserted together with i_tvalid: clear wins and the beat is not accepted.

## Configuration
- OFDM_DEMAP_BIT_REVERSE_EN defined: bit order within each output byte is reversed, so the first bit is at bit 0 of each byte, LSB-first on air. Applied at the output register input; no added latency.
- Undefined: bits are MSB-first as above.

## Structure
- Package ofdm_demap_pkg:
  - legal-order constants;
  - function is_legal_order;
  - typedef for order (width $clog2(MAX_ORDER)+1);
  - packer state enum {RUN, FLUSH}.
- Sub-module qam_gray_slicer: a registered, handshaked, one-axis slicer instantiated twice (I, Q), with parameters WIDTH_IN, FRAC_BITS, MAX_K and a k input.

## Test plan
- BPSK, OUT_WIDTH=32: 32 symbols alternating I=+0x0100/−0x0100, tlast on the 32nd → one word 0xAAAAAAAA with o_tlast=1.
- QAM-16: I=+0x0300, Q=−0x0100 (gray 10, 01 → 4'b1001) ×8, tlast on the 8th → 0x99999999 with tlast. Repeat with I=+0x0200 (tie → level 3) → same result.
- QAM-64, 6 symbols of 0x3F, tlast on the 6th → words 0xFFFFFFFF then 0xF0000000 with tlast. i_tready low for exactly one cycle (FLUSH).
- Order write 4→8 mid-packet → current packet stays QAM-16; next packet uses 8 bits/symbol. Write 5 → ignored, register reads back the prior order.
- o_tready held low 10 cycles mid-stream → no data lost or duplicated; o_tdata stable. Then reset mid-packet → o_tvalid=0 next cycle; next packet starts at cnt=0.
- With OFDM_DEMAP_BIT_REVERSE_EN, BPSK pattern 1,0,0,0,0,0,0,0 ×4 → 0x01010101.
